// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: loads a word into a universal shift register, rotates it
// count times, then returns the result. Optional abort port: SHIFT_SEQ_ABORT_EN.
module shift_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
`ifdef SHIFT_SEQ_ABORT_EN
   input  logic             abort,
`endif
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [1:0]       usr_mode,
   output logic [WIDTH-1:0] usr_d_in,
   input  logic [WIDTH-1:0] usr_d_out,
   output logic             busy
);

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_ROR  = 2'b01;
   localparam logic [1:0] MODE_ROL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      RESP
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] data_q, data_nx;
   logic             dir_q, dir_nx;
   logic [CNT_W-1:0] cnt_q, cnt_nx;
   logic             abort_req;

`ifdef SHIFT_SEQ_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         data_q <= '0;
         dir_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         state  <= state_nx;
         data_q <= data_nx;
         dir_q  <= dir_nx;
         cnt_q  <= cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      data_nx   = data_q;
      dir_nx    = dir_q;
      cnt_nx    = cnt_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      usr_mode  = MODE_HOLD;
      usr_d_in  = '0;

      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               data_nx  = cmd_data;
               dir_nx   = cmd_dir;
               cnt_nx   = cmd_count;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            if (abort_req) begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end else begin
               usr_mode = MODE_LOAD;
               usr_d_in = data_q;
               state_nx = (cnt_q != '0) ? SHIFT : RESP;
            end
         end
         SHIFT: begin
            if (abort_req) begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end else begin
               // feed the current value back so the register rotates in place
               usr_mode = dir_q ? MODE_ROL : MODE_ROR;
               usr_d_in = usr_d_out;
               cnt_nx   = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_nx = RESP;
               end
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign rsp_data = usr_d_out;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: vector table plus mid-command reset/abort sequences,
// with a behavioural 4-bit universal shift register on the usr_* side.
module tb_shift_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_data;
   logic       cmd_dir;
   logic [2:0] cmd_count;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_data;
   logic [1:0] usr_mode;
   logic [3:0] usr_d_in;
   logic [3:0] usr_d_out;
   logic       busy;
`ifdef SHIFT_SEQ_ABORT_EN
   logic       abort;
`endif

   int tests  = 0;
   int failed = 0;

   logic [3:0] sb[$];

   typedef struct {
      logic [3:0] data;
      logic       dir;
      logic [2:0] count;
      logic [3:0] exp;
      int         hold;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef SHIFT_SEQ_ABORT_EN
      .abort     (abort),
`endif
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_dir   (cmd_dir),
      .cmd_count (cmd_count),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .usr_mode  (usr_mode),
      .usr_d_in  (usr_d_in),
      .usr_d_out (usr_d_out),
      .busy      (busy)
   );

   // attached universal shift register
   logic [3:0] sr_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q <= 4'h0;
      end else begin
         case (usr_mode)
            2'b01:   sr_q <= {sr_q[0], sr_q[3:1]};
            2'b10:   sr_q <= {sr_q[2:0], sr_q[3]};
            2'b11:   sr_q <= usr_d_in;
            default: sr_q <= sr_q;
         endcase
      end
   end
   assign usr_d_out = sr_q;

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h @%0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_busy"}, 8'(busy), 8'h0);
      chk({tag, "_cmd_ready"}, 8'(cmd_ready), 8'h1);
      chk({tag, "_rsp_valid"}, 8'(rsp_valid), 8'h0);
      chk({tag, "_mode"}, 8'(usr_mode), 8'h0);
      chk({tag, "_d_in"}, 8'(usr_d_in), 8'h0);
   endtask

   // called and returns at a negedge; keeps cmd_valid high with junk
   // for the whole command to show it is ignored outside IDLE
   task automatic do_cmd(input logic [3:0] d, input logic dir,
                         input logic [2:0] n, input logic [3:0] exp,
                         input int hold);
      logic [3:0] held;
      int guard;
      guard = 0;
      while (!cmd_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!cmd_ready) begin
         tests++;
         failed++;
         $display("FAIL cmd_ready_timeout: got 0, expected 1");
         return;
      end
      cmd_data  = d;
      cmd_dir   = dir;
      cmd_count = n;
      cmd_valid = 1'b1;
      rsp_ready = (hold == 0);
      sb.push_back(exp);
      @(negedge clk);
      cmd_data  = ~d;
      cmd_dir   = ~dir;
      cmd_count = ~n;
      chk("load_mode", 8'(usr_mode), 8'h3);
      chk("load_d_in", 8'(usr_d_in), 8'(d));
      chk("load_cmd_ready", 8'(cmd_ready), 8'h0);
      chk("load_busy", 8'(busy), 8'h1);
      for (int i = 0; i < int'(n); i++) begin
         @(negedge clk);
         chk("shift_mode", 8'(usr_mode), dir ? 8'h2 : 8'h1);
         chk("shift_d_in", 8'(usr_d_in), 8'(usr_d_out));
         chk("shift_rsp_valid", 8'(rsp_valid), 8'h0);
      end
      @(negedge clk);
      chk("resp_valid", 8'(rsp_valid), 8'h1);
      chk("resp_mode", 8'(usr_mode), 8'h0);
      chk("resp_d_in", 8'(usr_d_in), 8'h0);
      held = rsp_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_valid", 8'(rsp_valid), 8'h1);
         chk("bp_data", 8'(rsp_data), 8'(held));
         chk("bp_mode", 8'(usr_mode), 8'h0);
         chk("bp_cmd_ready", 8'(cmd_ready), 8'h0);
      end
      rsp_ready = 1'b1;
      if (sb.size() == 0) begin
         tests++;
         failed++;
         $display("FAIL rsp_unexpected: got %0h, expected none", rsp_data);
      end else begin
         chk("rsp_data", 8'(rsp_data), 8'(sb.pop_front()));
      end
      @(negedge clk);
      idle_chk("after_rsp");
      cmd_valid = 1'b0;
   endtask

   // count=5 command killed in its 2nd SHIFT cycle by reset or abort
   task automatic kill_cmd(input bit use_abort);
      cmd_data  = 4'b0001;
      cmd_dir   = 1'b0;
      cmd_count = 3'd5;
      cmd_valid = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("kill_shift2_mode", 8'(usr_mode), 8'h1);
      if (use_abort) begin
`ifdef SHIFT_SEQ_ABORT_EN
         abort = 1'b1;
         #1;
         chk("abort_mode_now", 8'(usr_mode), 8'h0);
`endif
      end else begin
         reset = 1'b1;
      end
      @(negedge clk);
      reset = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      idle_chk(use_abort ? "abort" : "midreset");
      chk("kill_reg", 8'(usr_d_out), use_abort ? 8'h8 : 8'h0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("kill_no_rsp", 8'(rsp_valid), 8'h0);
      end
   endtask

   initial begin
      vecs[0] = '{4'b1011, 1'b0, 3'd1, 4'b1101, 0};
      vecs[1] = '{4'b0001, 1'b1, 3'd3, 4'b1000, 0};
      vecs[2] = '{4'b1010, 1'b0, 3'd0, 4'b1010, 0};
      vecs[3] = '{4'b1001, 1'b0, 3'd7, 4'b0011, 2};
      vecs[4] = '{4'b0110, 1'b1, 3'd2, 4'b1001, 0};
      vecs[5] = '{4'b1100, 1'b0, 3'd4, 4'b1100, 0};
      vecs[6] = '{4'b0111, 1'b1, 3'd5, 4'b1110, 5};
      vecs[7] = '{4'b1110, 1'b0, 3'd2, 4'b1011, 1};

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_data  = 4'h0;
      cmd_dir   = 1'b0;
      cmd_count = 3'd0;
      rsp_ready = 1'b1;
`ifdef SHIFT_SEQ_ABORT_EN
      abort     = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      idle_chk("reset");
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         do_cmd(vecs[i].data, vecs[i].dir, vecs[i].count,
                vecs[i].exp, vecs[i].hold);
      end

      kill_cmd(1'b0);
      do_cmd(4'b0101, 1'b1, 3'd1, 4'b1010, 0);
`ifdef SHIFT_SEQ_ABORT_EN
      kill_cmd(1'b1);
      do_cmd(4'b0011, 1'b0, 3'd3, 4'b0110, 0);
`endif

      chk("sb_empty", 8'(sb.size()), 8'h0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
